// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad key codes, the 4x4 keymap and the
// keypad debounce state encoding.
package calc_pkg;

   localparam logic [7:0] KEY_PLUS  = 8'h2B;
   localparam logic [7:0] KEY_MINUS = 8'h2D;
   localparam logic [7:0] KEY_MUL   = 8'h2A;
   localparam logic [7:0] KEY_EQ    = 8'h3D;
   localparam logic [7:0] KEY_CLR   = 8'h43;
   localparam logic [7:0] KEY_BS    = 8'h08;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS   = 2'd1,
      HELD    = 2'd2,
      RELEASE = 2'd3
   } deb_state_e;

   typedef enum logic [1:0] {
      SW_NONE  = 2'd0,
      SW_KEY   = 2'd1,
      SW_MULTI = 2'd2
   } sweep_kind_e;

   // Key index is row*4 + column.
   function automatic logic [7:0] key_code(input logic [3:0] idx);
      logic [7:0] code;
      case (idx)
         4'd0:    code = 8'h31;
         4'd1:    code = 8'h32;
         4'd2:    code = 8'h33;
         4'd3:    code = KEY_PLUS;
         4'd4:    code = 8'h34;
         4'd5:    code = 8'h35;
         4'd6:    code = 8'h36;
         4'd7:    code = KEY_MINUS;
         4'd8:    code = 8'h37;
         4'd9:    code = 8'h38;
         4'd10:   code = 8'h39;
         4'd11:   code = KEY_MUL;
         4'd12:   code = KEY_CLR;
         4'd13:   code = 8'h30;
         4'd14:   code = KEY_BS;
         4'd15:   code = KEY_EQ;
         default: code = 8'h00;
      endcase
      return code;
   endfunction

   // Only meaningful for a one-hot input.
   function automatic logic [3:0] onehot_index(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         idx = idx | (v[i] ? 4'(i) : 4'd0);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous bus whose idle level is all ones
// (active-low inputs such as keypad columns).
module sync_2ff #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= {W{1'b1}};
         sync_q <= {W{1'b1}};
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row sequencing, per-sweep decode and a
// debounce FSM that emits one btn_valid pulse per clean single-key press.
import calc_pkg::*;

module keypad_scanner #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_n,
   output logic [3:0] row_n,
   output logic       btn_valid,
   output logic [7:0] btn_char,
   output logic       key_down
);

   localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  DS_C      = CNT_W'(DEBOUNCE_SCANS);

   logic [3:0]        col_sync;
   logic [3:0]        col_low;
   logic              slot_end;
   logic              sweep_end;
   logic [15:0]       sweep_full;
   sweep_kind_e       sweep_kind;
   logic [3:0]        key_idx;
   logic [CNT_W-1:0]  cnt_inc;

   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [1:0]        row_q, row_d;
   logic [3:0]        row_n_q, row_n_d;
   logic [11:0]       sweep_q, sweep_d;
   deb_state_e        state_q, state_d;
   logic [3:0]        cand_q, cand_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              btn_valid_q, btn_valid_d;
   logic [7:0]        btn_char_q, btn_char_d;
   logic              key_down_q, key_down_d;

   sync_2ff #(.W(4)) u_col_sync (
      .clk (clk),
      .rst (rst),
      .d   (col_n),
      .q   (col_sync)
   );

   // Row 3 is never stored: the sweep is judged from rows 0-2 plus the live row-3 sample.
   always_comb begin
      col_low    = ~col_sync;
      slot_end   = (slot_q == SLOT_LAST);
      sweep_end  = slot_end && (row_q == 2'd3);
      sweep_full = {col_low, sweep_q};
      key_idx    = onehot_index(sweep_full);
      if (sweep_full == 16'd0) begin
         sweep_kind = SW_NONE;
      end else if ((sweep_full & (sweep_full - 16'd1)) == 16'd0) begin
         sweep_kind = SW_KEY;
      end else begin
         sweep_kind = SW_MULTI;
      end
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
   end

   always_comb begin
      slot_d  = slot_q;
      row_d   = row_q;
      row_n_d = row_n_q;
      sweep_d = sweep_q;
      if (slot_end) begin
         slot_d = {SLOT_W{1'b0}};
         row_d  = row_q + 2'd1;
         case (row_q)
            2'd0:    sweep_d[3:0]  = col_low;
            2'd1:    sweep_d[7:4]  = col_low;
            2'd2:    sweep_d[11:8] = col_low;
            default: sweep_d       = sweep_q;
         endcase
         case (row_d)
            2'd0:    row_n_d = 4'b1110;
            2'd1:    row_n_d = 4'b1101;
            2'd2:    row_n_d = 4'b1011;
            2'd3:    row_n_d = 4'b0111;
            default: row_n_d = 4'b1110;
         endcase
      end else begin
         slot_d = slot_q + SLOT_ONE;
      end
   end

   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      btn_valid_d = 1'b0;
      btn_char_d  = btn_char_q;
      key_down_d  = key_down_q;
      if (sweep_end) begin
         case (state_q)
            IDLE: begin
               if (sweep_kind == SW_KEY) begin
                  cand_d = key_idx;
                  cnt_d  = CNT_ONE;
                  if (CNT_ONE >= DS_C) begin
                     state_d     = HELD;
                     btn_valid_d = 1'b1;
                     btn_char_d  = key_code(key_idx);
                     key_down_d  = 1'b1;
                  end else begin
                     state_d = PRESS;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            PRESS: begin
               if ((sweep_kind == SW_KEY) && (key_idx == cand_q)) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= DS_C) begin
                     state_d     = HELD;
                     btn_valid_d = 1'b1;
                     btn_char_d  = key_code(key_idx);
                     key_down_d  = 1'b1;
                  end else begin
                     state_d = PRESS;
                  end
               end else if (sweep_kind == SW_KEY) begin
                  // A different single key restarts the count on that key.
                  cand_d  = key_idx;
                  cnt_d   = CNT_ONE;
                  state_d = PRESS;
               end else begin
                  cnt_d   = {CNT_W{1'b0}};
                  state_d = IDLE;
               end
            end
            HELD: begin
               if (sweep_kind == SW_NONE) begin
                  cnt_d = CNT_ONE;
                  if (CNT_ONE >= DS_C) begin
                     state_d    = IDLE;
                     key_down_d = 1'b0;
                  end else begin
                     state_d = RELEASE;
                  end
               end else begin
                  state_d = HELD;
               end
            end
            RELEASE: begin
               if (sweep_kind == SW_NONE) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= DS_C) begin
                     state_d    = IDLE;
                     key_down_d = 1'b0;
                  end else begin
                     state_d = RELEASE;
                  end
               end else begin
                  state_d = HELD;
               end
            end
            default: begin
               state_d    = IDLE;
               cnt_d      = {CNT_W{1'b0}};
               key_down_d = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q      <= {SLOT_W{1'b0}};
         row_q       <= 2'd0;
         row_n_q     <= 4'b1110;
         sweep_q     <= 12'd0;
         state_q     <= IDLE;
         cand_q      <= 4'd0;
         cnt_q       <= {CNT_W{1'b0}};
         btn_valid_q <= 1'b0;
         btn_char_q  <= 8'h00;
         key_down_q  <= 1'b0;
      end else begin
         slot_q      <= slot_d;
         row_q       <= row_d;
         row_n_q     <= row_n_d;
         sweep_q     <= sweep_d;
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         btn_valid_q <= btn_valid_d;
         btn_char_q  <= btn_char_d;
         key_down_q  <= key_down_d;
      end
   end

   assign row_n     = row_n_q;
   assign btn_valid = btn_valid_q;
   assign btn_char  = btn_char_q;
   assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural keypad matrix drives col_n from row_n,
// expected key codes are queued at stimulus time and popped on each btn_valid.
`timescale 1ns/1ps
module tb_keypad_scanner;

   logic       clk;
   logic       rst;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic       btn_valid;
   logic [7:0] btn_char;
   logic       key_down;

   logic [15:0] keys;
   logic [7:0]  exp_q[$];
   int          n_cmp;
   int          n_err;
   int          cyc;
   int          last_pulse;
   int          prev_pulse;
   int          plus_pulse;
   logic        prev_valid;
   logic [7:0]  prev_char;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .col_n     (col_n),
      .row_n     (row_n),
      .btn_valid (btn_valid),
      .btn_char  (btn_char),
      .key_down  (key_down)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a pressed key shorts its column to its row while that row is low.
   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Returns at the falling edge just after row 0 is re-entered (end of a sweep).
   task automatic wait_sweeps(input int n);
      logic [3:0] prev;
      int         budget;
      bit         seen;
      for (int i = 0; i < n; i++) begin
         seen   = 1'b0;
         budget = 0;
         while (!seen && budget < 40) begin
            prev = row_n;
            @(negedge clk);
            budget++;
            seen = (row_n == 4'b1110) && (prev != 4'b1110);
         end
         if (!seen) check_eq("sweep_timeout", 32'(seen), 32'd1);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (btn_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_pulse", 32'(btn_valid), 32'd0);
            end else begin
               check_eq("btn_char", 32'(btn_char), 32'(exp_q.pop_front()));
            end
            prev_pulse = last_pulse;
            last_pulse = cyc;
         end
         if (btn_valid && prev_valid) check_eq("pulse_width", 32'(prev_valid), 32'd0);
         if (btn_char !== prev_char) check_eq("char_hold", 32'(btn_valid), 32'd1);
      end
      prev_valid = btn_valid;
      prev_char  = btn_char;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0;
      last_pulse = 0; prev_pulse = 0; plus_pulse = 0;
      prev_valid = 1'b0; prev_char = 8'h00;
      keys = 16'd0;
      rst  = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_row_n", 32'(row_n), 32'(4'b1110));
      check_eq("rst_valid", 32'(btn_valid), 32'd0);
      check_eq("rst_char", 32'(btn_char), 32'h00);
      check_eq("rst_key_down", 32'(key_down), 32'd0);
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         check_eq("row_seq", 32'(row_n), 32'(~(4'b0001 << ((k / 4) % 4)) & 4'hF));
      end

      // '5' held for 10 sweeps then released
      exp_q.push_back(8'h35);
      keys = 16'h0020;
      wait_sweeps(3);
      check_eq("press_latency_5", 32'(btn_valid), 32'd1);
      wait_sweeps(7);
      check_eq("held_key_down", 32'(key_down), 32'd1);
      keys = 16'd0;
      wait_sweeps(2);
      check_eq("release_pending", 32'(key_down), 32'd1);
      wait_sweeps(1);
      check_eq("release_done", 32'(key_down), 32'd0);
      check_eq("pulse_5_seen", 32'(exp_q.size()), 32'd0);

      // Backspace bouncing for 2 sweeps, then stable
      for (int i = 0; i < 32; i++) begin
         if (i % 5 == 0) keys = keys ^ 16'h4000;
         @(negedge clk);
      end
      check_eq("bounce_no_down", 32'(key_down), 32'd0);
      exp_q.push_back(8'h08);
      keys = 16'h4000;
      wait_sweeps(4);
      check_eq("pulse_bs_seen", 32'(exp_q.size()), 32'd0);
      keys = 16'd0;
      wait_sweeps(4);

      // '1' and '*' together, then '*' released
      keys = 16'h0801;
      wait_sweeps(8);
      check_eq("multi_no_down", 32'(key_down), 32'd0);
      exp_q.push_back(8'h31);
      keys = 16'h0001;
      wait_sweeps(3);
      check_eq("press_latency_1", 32'(btn_valid), 32'd1);
      keys = 16'd0;
      wait_sweeps(4);

      // '+', release with an early re-press, then '='
      exp_q.push_back(8'h2B);
      keys = 16'h0008;
      wait_sweeps(3);
      check_eq("press_latency_plus", 32'(btn_valid), 32'd1);
      plus_pulse = last_pulse;
      wait_sweeps(1);
      keys = 16'd0;
      wait_sweeps(1);
      keys = 16'h0008;
      wait_sweeps(3);
      check_eq("repress_held", 32'(key_down), 32'd1);
      keys = 16'd0;
      wait_sweeps(3);
      check_eq("plus_released", 32'(key_down), 32'd0);
      exp_q.push_back(8'h3D);
      keys = 16'h8000;
      wait_sweeps(3);
      check_eq("press_latency_eq", 32'(btn_valid), 32'd1);
      check_eq("plus_eq_gap", 32'((last_pulse - plus_pulse) >= 48), 32'd1);
      keys = 16'd0;
      wait_sweeps(4);

      // Reset in the middle of a press
      keys = 16'h0020;
      wait_sweeps(2);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_row_n", 32'(row_n), 32'(4'b1110));
      check_eq("mid_rst_valid", 32'(btn_valid), 32'd0);
      check_eq("mid_rst_char", 32'(btn_char), 32'h00);
      check_eq("mid_rst_key_down", 32'(key_down), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(8'h35);
      wait_sweeps(2);
      check_eq("post_rst_no_pulse", 32'(btn_valid), 32'd0);
      check_eq("post_rst_no_down", 32'(key_down), 32'd0);
      wait_sweeps(1);
      check_eq("post_rst_latency", 32'(btn_valid), 32'd1);
      keys = 16'd0;
      wait_sweeps(4);
      check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
